// File: rtl/lsu_dmem.sv
// lsu_dmem: load/store unit with an internal little-endian byte memory.
// Accepts one RV32I load/store per handshake, splits misaligned accesses
// into two beats, and returns a single-cycle response pulse.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; all req_* fields are captured on that edge.
// req_ready is high only in IDLE (and not in reset), so the requester
// holds req_valid/req_* until it sees req_ready. rsp_valid is a one-cycle
// pulse with no back-pressure; rsp_rdata/rsp_err hold until the next one.
module lsu_dmem #(
  parameter int    DEPTH_BYTES    = 4096,
  parameter int    BASE           = 152,
  parameter int    WAIT_STATES    = 0,
  parameter bit    ALLOW_MISALIGN = 1'b1,
  parameter string INIT_FILE      = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [7:0]    mem [DEPTH_BYTES];

  // Captured request.
  logic          r_we;
  logic [2:0]    r_f3;
  logic [AW-1:0] r_ea;
  logic [31:0]   r_wdata;

  logic [31:0]   acc, acc_nx;
  logic [3:0]    wcnt;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic [AW-1:0] ea_in;
  logic          illegal_in;
  logic [2:0]    nb, first, cnt0;
  logic          misal, beat_done;
  logic [3:0]    sel;
  logic [31:0]   ext;
  logic          unused_addr;

  // Access size in bytes from funct3[1:0].
  function automatic logic [2:0] nbytes_of(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Halfword on an odd address, or word off a word boundary.
  function automatic logic misal_of(input logic [1:0] sz, input logic [1:0] off);
    return (sz == 2'b01 && off[0]) || (sz == 2'b10 && off != 2'b00);
  endfunction

  // Memory is a power of two, so dropping the high address bits is the wrap.
  assign ea_in       = req_addr[AW-1:0] + AW'(BASE);
  assign unused_addr = ^req_addr[31:AW];
  assign illegal_in  = (req_funct3 inside {3'b011, 3'b110, 3'b111}) ||
                       (req_we && req_funct3[2]) ||
                       (!ALLOW_MISALIGN && misal_of(req_funct3[1:0], ea_in[1:0]));

  // BEAT0 takes bytes up to the end of the aligned word, BEAT1 the rest.
  assign nb        = nbytes_of(r_f3[1:0]);
  assign first     = 3'd4 - {1'b0, r_ea[1:0]};
  assign cnt0      = (nb < first) ? nb : first;
  assign misal     = misal_of(r_f3[1:0], r_ea[1:0]);
  assign beat_done = (wcnt == 4'(WAIT_STATES));

  // Byte selection for the current beat, gathered load data, and next state.
  always_comb begin
    state_nx = state;
    sel      = '0;
    acc_nx   = acc;
    for (int k = 0; k < 4; k++) begin
      if (state == BEAT1) sel[k] = (3'(k) >= cnt0) && (3'(k) < nb);
      else                sel[k] = (3'(k) < cnt0);
      if (sel[k]) acc_nx[8*k +: 8] = mem[r_ea + AW'(k)];
    end
    case (state)
      IDLE:    if (req_valid) state_nx = illegal_in ? RESP : BEAT0;
      BEAT0:   if (beat_done) state_nx = misal ? BEAT1 : RESP;
      BEAT1:   if (beat_done) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Width/sign extension of the gathered bytes; stores return zero.
  always_comb begin
    ext = '0;
    case (r_f3)
      3'b000:  ext = {{24{acc_nx[7]}}, acc_nx[7:0]};
      3'b001:  ext = {{16{acc_nx[15]}}, acc_nx[15:0]};
      3'b010:  ext = acc_nx;
      3'b100:  ext = {24'd0, acc_nx[7:0]};
      3'b101:  ext = {16'd0, acc_nx[15:0]};
      default: ext = '0;
    endcase
    if (r_we) ext = '0;
  end

  // Control state, request capture, wait counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wcnt    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_f3    <= req_funct3;
            r_ea    <= ea_in;
            r_wdata <= req_wdata;
            acc     <= '0;
            wcnt    <= '0;
            if (illegal_in) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
            end
          end
        end
        BEAT0, BEAT1: begin
          if (beat_done) begin
            wcnt <= '0;
            acc  <= acc_nx;
            if (state_nx == RESP) begin
              rdata_q <= ext;
              err_q   <= 1'b0;
            end
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Byte-enabled store on the final edge of each beat; a reset edge writes nothing.
  always_ff @(posedge clk) begin
    if (!rst && (state == BEAT0 || state == BEAT1) && beat_done && r_we) begin
      for (int k = 0; k < 4; k++) begin
        if (sel[k]) mem[r_ea + AW'(k)] <= r_wdata[8*k +: 8];
      end
    end
  end

  assign req_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE) && !rst;
  assign rsp_valid = (state == RESP) && !rst;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_lsu_dmem.sv
// tb_lsu_dmem: checks lsu_dmem with three instances sharing clk/rst and the
// request fields: u0 defaults, u1 with two wait states, u2 without
// misaligned support. Each instance has its own req_valid.
module tb_lsu_dmem;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid, req_ready, rsp_valid, rsp_err, busy;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] rsp_rdata [3];
  logic [1:0]  dbg_state [3];

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  logic [31:0] obs_data;
  logic        obs_err, obs_timeout, obs_pulse1, obs_beat1;
  int          obs_lat;

  // d: instance, lat: negedges from the acceptance edge to rsp_valid, b1: BEAT1 seen
  typedef struct packed {
    logic [1:0]  d;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        err;
    logic [3:0]  lat;
    logic        b1;
  } op_t;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  lsu_dmem u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .busy(busy[0]), .dbg_state(dbg_state[0])
  );

  lsu_dmem #(.WAIT_STATES(2)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .busy(busy[1]), .dbg_state(dbg_state[1])
  );

  lsu_dmem #(.ALLOW_MISALIGN(1'b0)) u2 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]),
    .busy(busy[2]), .dbg_state(dbg_state[2])
  );

  // ---------------- driver ----------------
  // One request on instance d; waits for the response and records what it saw.
  task automatic send(input int d, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    obs_timeout = 1'b0;
    obs_beat1   = 1'b0;
    obs_pulse1  = 1'b0;
    obs_lat     = 0;
    obs_data    = 'x;
    obs_err     = 1'bx;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid[d] = 1'b1;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      obs_timeout  = 1'b1;
      req_valid[d] = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      req_valid[d] = 1'b0;
      // Scramble the request fields: the unit must use its captured copy.
      req_we     = 1'($urandom_range(0, 1));
      req_funct3 = 3'($urandom_range(0, 7));
      req_addr   = $urandom;
      req_wdata  = $urandom;
      obs_lat = 1;
      while (rsp_valid[d] !== 1'b1 && obs_lat < 40) begin
        if (dbg_state[d] == 2'd2) obs_beat1 = 1'b1;
        @(negedge clk);
        obs_lat++;
      end
      if (obs_lat >= 40) obs_timeout = 1'b1;
      obs_data = rsp_rdata[d];
      obs_err  = rsp_err[d];
      @(negedge clk);
      obs_pulse1 = (rsp_valid[d] === 1'b0);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 3'b000) begin errors++; $display("FAIL reset req_ready got %b want 000", req_ready); end
    checks++;
    if (busy !== 3'b000) begin errors++; $display("FAIL reset busy got %b want 000", busy); end
    checks++;
    if (rsp_valid !== 3'b000) begin errors++; $display("FAIL reset rsp_valid got %b want 000", rsp_valid); end
    checks++;
    if (rsp_err !== 3'b000) begin errors++; $display("FAIL reset rsp_err got %b want 000", rsp_err); end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (rsp_rdata[j] !== 32'd0) begin errors++; $display("FAIL reset rsp_rdata[%0d] got %08h want 00000000", j, rsp_rdata[j]); end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 3'b111) begin errors++; $display("FAIL reset release req_ready got %b want 111", req_ready); end
  endtask

  task automatic test_store_load();
    op_t ops [6];
    logic [31:0] e;
    ops = '{
      '{2'd0, 1'b1, 3'b010, 32'd0, 32'h12345680, 32'h00000000, 1'b0, 4'd2, 1'b0},
      '{2'd0, 1'b0, 3'b010, 32'd0, 32'h0,        32'h12345680, 1'b0, 4'd2, 1'b0},
      '{2'd0, 1'b0, 3'b000, 32'd0, 32'h0,        32'hFFFFFF80, 1'b0, 4'd2, 1'b0},
      '{2'd0, 1'b0, 3'b100, 32'd0, 32'h0,        32'h00000080, 1'b0, 4'd2, 1'b0},
      '{2'd0, 1'b0, 3'b001, 32'd2, 32'h0,        32'h00001234, 1'b0, 4'd2, 1'b0},
      '{2'd0, 1'b0, 3'b101, 32'd0, 32'h0,        32'h00005680, 1'b0, 4'd2, 1'b0}
    };
    foreach (ops[i]) begin
      exp_q.push_back(ops[i].exp);
      send(int'(ops[i].d), ops[i].we, ops[i].f3, ops[i].addr, ops[i].wdata);
      e = exp_q.pop_front();
      checks += 5;
      if (obs_timeout) begin errors += 5; $display("FAIL store_load[%0d] no response", i); end
      else begin
        if (obs_data !== e) begin errors++; $display("FAIL store_load[%0d] rdata got %08h want %08h", i, obs_data, e); end
        if (obs_err !== ops[i].err) begin errors++; $display("FAIL store_load[%0d] err got %b want %b", i, obs_err, ops[i].err); end
        if (obs_lat != int'(ops[i].lat)) begin errors++; $display("FAIL store_load[%0d] latency got %0d want %0d", i, obs_lat, ops[i].lat); end
        if (obs_beat1 !== ops[i].b1) begin errors++; $display("FAIL store_load[%0d] beat1 got %b want %b", i, obs_beat1, ops[i].b1); end
        if (!obs_pulse1) begin errors++; $display("FAIL store_load[%0d] rsp_valid width got >1 want 1", i); end
      end
    end
  endtask

  task automatic test_byte_enable();
    op_t ops [6];
    logic [31:0] e;
    ops = '{
      '{2'd0, 1'b1, 3'b000, 32'd1, 32'hAAAAAAEE, 32'h00000000, 1'b0, 4'd2, 1'b0},
      '{2'd0, 1'b0, 3'b010, 32'd0, 32'h0,        32'h1234EE80, 1'b0, 4'd2, 1'b0},
      '{2'd0, 1'b1, 3'b001, 32'd2, 32'h5555BEEF, 32'h00000000, 1'b0, 4'd2, 1'b0},
      '{2'd0, 1'b0, 3'b010, 32'd0, 32'h0,        32'hBEEFEE80, 1'b0, 4'd2, 1'b0},
      '{2'd0, 1'b0, 3'b001, 32'd1, 32'h0,        32'hFFFFEFEE, 1'b0, 4'd3, 1'b1},
      '{2'd0, 1'b0, 3'b100, 32'd3, 32'h0,        32'h000000BE, 1'b0, 4'd2, 1'b0}
    };
    foreach (ops[i]) begin
      exp_q.push_back(ops[i].exp);
      send(int'(ops[i].d), ops[i].we, ops[i].f3, ops[i].addr, ops[i].wdata);
      e = exp_q.pop_front();
      checks += 5;
      if (obs_timeout) begin errors += 5; $display("FAIL byte_enable[%0d] no response", i); end
      else begin
        if (obs_data !== e) begin errors++; $display("FAIL byte_enable[%0d] rdata got %08h want %08h", i, obs_data, e); end
        if (obs_err !== ops[i].err) begin errors++; $display("FAIL byte_enable[%0d] err got %b want %b", i, obs_err, ops[i].err); end
        if (obs_lat != int'(ops[i].lat)) begin errors++; $display("FAIL byte_enable[%0d] latency got %0d want %0d", i, obs_lat, ops[i].lat); end
        if (obs_beat1 !== ops[i].b1) begin errors++; $display("FAIL byte_enable[%0d] beat1 got %b want %b", i, obs_beat1, ops[i].b1); end
        if (!obs_pulse1) begin errors++; $display("FAIL byte_enable[%0d] rsp_valid width got >1 want 1", i); end
      end
    end
  endtask

  task automatic test_misaligned();
    op_t ops [9];
    logic [31:0] e;
    ops = '{
      '{2'd0, 1'b1, 3'b010, 32'd4, 32'hAABBCCDD, 32'h00000000, 1'b0, 4'd2, 1'b0},
      '{2'd0, 1'b1, 3'b010, 32'd8, 32'h11223344, 32'h00000000, 1'b0, 4'd2, 1'b0},
      '{2'd0, 1'b0, 3'b010, 32'd6, 32'h0,        32'h3344AABB, 1'b0, 4'd3, 1'b1},
      '{2'd0, 1'b0, 3'b001, 32'd7, 32'h0,        32'h000044AA, 1'b0, 4'd3, 1'b1},
      '{2'd0, 1'b0, 3'b100, 32'd5, 32'h0,        32'h000000CC, 1'b0, 4'd2, 1'b0},
      '{2'd1, 1'b1, 3'b010, 32'd4, 32'hAABBCCDD, 32'h00000000, 1'b0, 4'd4, 1'b0},
      '{2'd1, 1'b1, 3'b010, 32'd8, 32'h11223344, 32'h00000000, 1'b0, 4'd4, 1'b0},
      '{2'd1, 1'b0, 3'b010, 32'd6, 32'h0,        32'h3344AABB, 1'b0, 4'd7, 1'b1},
      '{2'd1, 1'b0, 3'b010, 32'd8, 32'h0,        32'h11223344, 1'b0, 4'd4, 1'b0}
    };
    foreach (ops[i]) begin
      exp_q.push_back(ops[i].exp);
      send(int'(ops[i].d), ops[i].we, ops[i].f3, ops[i].addr, ops[i].wdata);
      e = exp_q.pop_front();
      checks += 5;
      if (obs_timeout) begin errors += 5; $display("FAIL misaligned[%0d] no response", i); end
      else begin
        if (obs_data !== e) begin errors++; $display("FAIL misaligned[%0d] rdata got %08h want %08h", i, obs_data, e); end
        if (obs_err !== ops[i].err) begin errors++; $display("FAIL misaligned[%0d] err got %b want %b", i, obs_err, ops[i].err); end
        if (obs_lat != int'(ops[i].lat)) begin errors++; $display("FAIL misaligned[%0d] latency got %0d want %0d", i, obs_lat, ops[i].lat); end
        if (obs_beat1 !== ops[i].b1) begin errors++; $display("FAIL misaligned[%0d] beat1 got %b want %b", i, obs_beat1, ops[i].b1); end
        if (!obs_pulse1) begin errors++; $display("FAIL misaligned[%0d] rsp_valid width got >1 want 1", i); end
      end
    end
  endtask

  task automatic test_errors();
    op_t ops [13];
    logic [31:0] e;
    ops = '{
      '{2'd0, 1'b0, 3'b011, 32'd0, 32'h0,        32'h00000000, 1'b1, 4'd1, 1'b0},
      '{2'd0, 1'b1, 3'b011, 32'd0, 32'hDEADBEEF, 32'h00000000, 1'b1, 4'd1, 1'b0},
      '{2'd0, 1'b1, 3'b100, 32'd0, 32'h00000011, 32'h00000000, 1'b1, 4'd1, 1'b0},
      '{2'd0, 1'b1, 3'b101, 32'd0, 32'h00002222, 32'h00000000, 1'b1, 4'd1, 1'b0},
      '{2'd0, 1'b0, 3'b110, 32'd0, 32'h0,        32'h00000000, 1'b1, 4'd1, 1'b0},
      '{2'd0, 1'b0, 3'b111, 32'd0, 32'h0,        32'h00000000, 1'b1, 4'd1, 1'b0},
      '{2'd0, 1'b0, 3'b010, 32'd0, 32'h0,        32'hBEEFEE80, 1'b0, 4'd2, 1'b0},
      '{2'd2, 1'b0, 3'b001, 32'd1, 32'h0,        32'h00000000, 1'b1, 4'd1, 1'b0},
      '{2'd2, 1'b0, 3'b010, 32'd2, 32'h0,        32'h00000000, 1'b1, 4'd1, 1'b0},
      '{2'd2, 1'b1, 3'b010, 32'd6, 32'h01020304, 32'h00000000, 1'b1, 4'd1, 1'b0},
      '{2'd2, 1'b1, 3'b001, 32'd2, 32'h00008001, 32'h00000000, 1'b0, 4'd2, 1'b0},
      '{2'd2, 1'b0, 3'b001, 32'd2, 32'h0,        32'hFFFF8001, 1'b0, 4'd2, 1'b0},
      '{2'd2, 1'b0, 3'b000, 32'd3, 32'h0,        32'hFFFFFF80, 1'b0, 4'd2, 1'b0}
    };
    foreach (ops[i]) begin
      exp_q.push_back(ops[i].exp);
      send(int'(ops[i].d), ops[i].we, ops[i].f3, ops[i].addr, ops[i].wdata);
      e = exp_q.pop_front();
      checks += 5;
      if (obs_timeout) begin errors += 5; $display("FAIL errors[%0d] no response", i); end
      else begin
        if (obs_data !== e) begin errors++; $display("FAIL errors[%0d] rdata got %08h want %08h", i, obs_data, e); end
        if (obs_err !== ops[i].err) begin errors++; $display("FAIL errors[%0d] err got %b want %b", i, obs_err, ops[i].err); end
        if (obs_lat != int'(ops[i].lat)) begin errors++; $display("FAIL errors[%0d] latency got %0d want %0d", i, obs_lat, ops[i].lat); end
        if (obs_beat1 !== ops[i].b1) begin errors++; $display("FAIL errors[%0d] beat1 got %b want %b", i, obs_beat1, ops[i].b1); end
        if (!obs_pulse1) begin errors++; $display("FAIL errors[%0d] rsp_valid width got >1 want 1", i); end
      end
    end
  endtask

  // 3942 = 4096 - 152 - 2: the word straddles the top of memory.
  task automatic test_wrap();
    op_t ops [6];
    logic [31:0] e;
    ops = '{
      '{2'd0, 1'b1, 3'b010, 32'd3942, 32'hCAFEF00D, 32'h00000000, 1'b0, 4'd3, 1'b1},
      '{2'd0, 1'b0, 3'b010, 32'd3942, 32'h0,        32'hCAFEF00D, 1'b0, 4'd3, 1'b1},
      '{2'd0, 1'b0, 3'b101, 32'd3944, 32'h0,        32'h0000CAFE, 1'b0, 4'd2, 1'b0},
      '{2'd0, 1'b0, 3'b100, 32'd3944, 32'h0,        32'h000000FE, 1'b0, 4'd2, 1'b0},
      '{2'd0, 1'b0, 3'b000, 32'd3945, 32'h0,        32'hFFFFFFCA, 1'b0, 4'd2, 1'b0},
      '{2'd0, 1'b0, 3'b101, 32'd3942, 32'h0,        32'h0000F00D, 1'b0, 4'd2, 1'b0}
    };
    foreach (ops[i]) begin
      exp_q.push_back(ops[i].exp);
      send(int'(ops[i].d), ops[i].we, ops[i].f3, ops[i].addr, ops[i].wdata);
      e = exp_q.pop_front();
      checks += 5;
      if (obs_timeout) begin errors += 5; $display("FAIL wrap[%0d] no response", i); end
      else begin
        if (obs_data !== e) begin errors++; $display("FAIL wrap[%0d] rdata got %08h want %08h", i, obs_data, e); end
        if (obs_err !== ops[i].err) begin errors++; $display("FAIL wrap[%0d] err got %b want %b", i, obs_err, ops[i].err); end
        if (obs_lat != int'(ops[i].lat)) begin errors++; $display("FAIL wrap[%0d] latency got %0d want %0d", i, obs_lat, ops[i].lat); end
        if (obs_beat1 !== ops[i].b1) begin errors++; $display("FAIL wrap[%0d] beat1 got %b want %b", i, obs_beat1, ops[i].b1); end
        if (!obs_pulse1) begin errors++; $display("FAIL wrap[%0d] rsp_valid width got >1 want 1", i); end
      end
    end
  endtask

  // Misaligned sw @6 aborted by reset in BEAT1: bytes 6-7 written, 8-9 kept.
  task automatic test_reset_mid_op();
    op_t ops [2];
    logic [31:0] e;
    int n;
    logic saw_rsp;
    saw_rsp = 1'b0;
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'd6; req_wdata = 32'h99887766;
    req_valid[0] = 1'b1;
    n = 0;
    while (req_ready[0] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 0;
    while (dbg_state[0] !== 2'd2 && n < 20) begin
      if (rsp_valid[0] === 1'b1) saw_rsp = 1'b1;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL reset_mid_op beat1 not reached got state %0d want 2", dbg_state[0]); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL reset_mid_op in reset ready/busy got %b/%b want 0/0", req_ready[0], busy[0]);
    end
    rst = 1'b0;
    repeat (5) begin
      if (rsp_valid[0] === 1'b1) saw_rsp = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw_rsp) begin errors++; $display("FAIL reset_mid_op rsp_valid got 1 want 0"); end
    ops = '{
      '{2'd0, 1'b0, 3'b010, 32'd6, 32'h0, 32'h33447766, 1'b0, 4'd3, 1'b1},
      '{2'd0, 1'b0, 3'b101, 32'd8, 32'h0, 32'h00003344, 1'b0, 4'd2, 1'b0}
    };
    foreach (ops[i]) begin
      exp_q.push_back(ops[i].exp);
      send(int'(ops[i].d), ops[i].we, ops[i].f3, ops[i].addr, ops[i].wdata);
      e = exp_q.pop_front();
      checks += 3;
      if (obs_timeout) begin errors += 3; $display("FAIL reset_mid_op[%0d] no response", i); end
      else begin
        if (obs_data !== e) begin errors++; $display("FAIL reset_mid_op[%0d] rdata got %08h want %08h", i, obs_data, e); end
        if (obs_err !== ops[i].err) begin errors++; $display("FAIL reset_mid_op[%0d] err got %b want %b", i, obs_err, ops[i].err); end
        if (obs_lat != int'(ops[i].lat)) begin errors++; $display("FAIL reset_mid_op[%0d] latency got %0d want %0d", i, obs_lat, ops[i].lat); end
      end
    end
  endtask

  // req_valid held high: aligned loads should be accepted every 3 cycles.
  task automatic test_back_to_back();
    int last, accepts;
    logic overlap;
    logic [31:0] e;
    last = -1; accepts = 0; overlap = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) begin
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'd0; req_wdata = 32'h0;
        req_valid[0] = 1'b1;
      end
      if (i == 18) req_valid[0] = 1'b0;
      if (req_ready[0] === 1'b1 && busy[0] === 1'b1) overlap = 1'b1;
      if (rsp_valid[0] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL back_to_back unexpected response got %08h", rsp_rdata[0]); end
        else begin
          e = exp_q.pop_front();
          if (rsp_rdata[0] !== e) begin errors++; $display("FAIL back_to_back rdata got %08h want %08h", rsp_rdata[0], e); end
        end
      end
      if (req_valid[0] === 1'b1 && req_ready[0] === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (i - last != 3) begin errors++; $display("FAIL back_to_back spacing got %0d want 3", i - last); end
        end
        last = i;
        accepts++;
        exp_q.push_back(32'hBEEFEE80);
      end
    end
    checks++;
    if (accepts != 6) begin errors++; $display("FAIL back_to_back accepts got %0d want 6", accepts); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL back_to_back pending got %0d want 0", exp_q.size()); end
    checks++;
    if (overlap) begin errors++; $display("FAIL back_to_back ready_and_busy got 1 want 0"); end
    exp_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_store_load();
    test_byte_enable();
    test_misaligned();
    test_errors();
    test_wrap();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
